// File: rtl/ripple_count_capture.sv
// ripple_count_capture: brings an asynchronous, bit-rippling counter into the
// clk domain. Skew transients are filtered out, and the wrapping count is
// extended into a wide running total. A req/ack port returns coherent snapshots.
module ripple_count_capture #(
  parameter int IN_W       = 3,
  parameter int OUT_W      = 16,
  parameter int STABLE_CYC = 2,
  parameter int MAX_DELTA  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IN_W-1:0]  ripple_q,
  input  logic             clear,
  input  logic             snap_req,
  input  logic             snap_ack,
  output logic [OUT_W-1:0] total_count,
  output logic             init_done,
  output logic [OUT_W-1:0] snap_count,
  output logic             snap_valid,
  output logic             jump_err,
  output logic             overflow
);

  localparam int CNT_W = (STABLE_CYC < 1) ? 1 : $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] STAB_PRE = CNT_W'(STABLE_CYC - 1);
  localparam logic [IN_W:0]    MAXD     = (IN_W + 1)'(MAX_DELTA);

  typedef enum logic {S_INIT, S_TRACK} st_e;
  typedef enum logic {SN_IDLE, SN_HOLD} sn_e;

  // synchronizer / filter state
  logic [IN_W-1:0]  sync1_q, sync2_q, prev_q;
  logic [2:0]       vld_pipe_q;   // marks which stages hold real post-reset samples
  logic [CNT_W-1:0] stab_q, stab_d;
  logic             same, accept;

  // main FSM / datapath
  st_e              state_q, state_d;
  logic [IN_W-1:0]  base_q, base_d, delta;
  logic [OUT_W-1:0] total_q, total_d;
  logic [OUT_W:0]   sum;
  logic             je_q, je_d, ov_q, ov_d;

  // snapshot FSM
  sn_e              sn_q, sn_d;
  logic [OUT_W-1:0] snc_q, snc_d;
  logic             snap_load;

  // Two-flop synchronizer, previous-sample register and stability counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      vld_pipe_q <= '0;
      stab_q     <= '0;
    end else begin
      sync1_q    <= ripple_q;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      vld_pipe_q <= {vld_pipe_q[1:0], 1'b1};
      stab_q     <= stab_d;
    end
  end

  // Count equal samples and fire accept once, when the count reaches STABLE_CYC.
  // Reset values of the synchronizer are not samples, so they never count.
  always_comb begin
    same   = vld_pipe_q[2] && (sync2_q == prev_q);
    stab_d = '0;
    if (same) stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
    accept = same && (stab_q == STAB_PRE);
  end

  // Main FSM, baseline, total and sticky flags registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      base_q  <= '0;
      total_q <= '0;
      je_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      total_q <= total_d;
      je_q    <= je_d;
      ov_q    <= ov_d;
    end
  end

  // Next-state: the first accepted value becomes the baseline.
  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && accept) state_d = S_TRACK;
  end

  // Accumulate the modular delta; clear wins over a same-cycle delta.
  always_comb begin
    base_d  = base_q;
    total_d = total_q;
    je_d    = je_q;
    ov_d    = ov_q;
    delta   = sync2_q - base_q;
    sum     = {1'b0, total_q} + (OUT_W + 1)'(delta);
    if (accept) base_d = sync2_q;
    if (clear) begin
      total_d = '0;
      je_d    = 1'b0;
      ov_d    = 1'b0;
    end else if (accept && state_q == S_TRACK && delta != '0) begin
      total_d = sum[OUT_W-1:0];
      if (sum[OUT_W])            ov_d = 1'b1;
      if ({1'b0, delta} > MAXD)  je_d = 1'b1;
    end
  end

  // Main outputs.
  always_comb begin
    init_done   = (state_q == S_TRACK);
    total_count = total_q;
    jump_err    = je_q;
    overflow    = ov_q;
  end

  // Snapshot state and held value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sn_q  <= SN_IDLE;
      snc_q <= '0;
    end else begin
      sn_q  <= sn_d;
      snc_q <= snc_d;
    end
  end

  // Snapshot next-state: captures the pre-update total, reloads on ack+req.
  always_comb begin
    sn_d      = sn_q;
    snap_load = 1'b0;
    case (sn_q)
      SN_IDLE: if (snap_req) begin
        sn_d      = SN_HOLD;
        snap_load = 1'b1;
      end
      SN_HOLD: if (snap_ack) begin
        if (snap_req) snap_load = 1'b1;
        else          sn_d      = SN_IDLE;
      end
      default: sn_d = SN_IDLE;
    endcase
    snc_d = snap_load ? total_q : snc_q;
  end

  // Snapshot outputs.
  always_comb begin
    snap_valid = (sn_q == SN_HOLD);
    snap_count = snc_q;
  end

endmodule

// File: tb/tb_ripple_count_capture.sv
// Bench for ripple_count_capture: two instances (16-bit and 4-bit totals)
// share one stimulus stream; a value-level model predicts both.
module tb_ripple_count_capture;

  logic        clk, reset_n, clr, sreq, sack;
  logic [2:0]  ripple;
  logic [15:0] tot16, sc16;
  logic [3:0]  tot4, sc4;
  logic        init16, sv16, je16, ov16;
  logic        init4, sv4, je4, ov4;

  int checks = 0;
  int failures = 0;

  // value-level reference model
  bit m_init, m_je, m_ov16, m_ov4, m_sv;
  int m_base, m_t16, m_t4, m_sc16, m_sc4;

  ripple_count_capture #(.IN_W(3), .OUT_W(16), .STABLE_CYC(2), .MAX_DELTA(3)) dut16 (
    .clk(clk), .reset_n(reset_n), .ripple_q(ripple), .clear(clr),
    .snap_req(sreq), .snap_ack(sack), .total_count(tot16), .init_done(init16),
    .snap_count(sc16), .snap_valid(sv16), .jump_err(je16), .overflow(ov16));

  ripple_count_capture #(.IN_W(3), .OUT_W(4), .STABLE_CYC(2), .MAX_DELTA(3)) dut4 (
    .clk(clk), .reset_n(reset_n), .ripple_q(ripple), .clear(clr),
    .snap_req(sreq), .snap_ack(sack), .total_count(tot4), .init_done(init4),
    .snap_count(sc4), .snap_valid(sv4), .jump_err(je4), .overflow(ov4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".tot16"}, int'(tot16), m_t16);
    chk({tag, ".tot4"},  int'(tot4),  m_t4);
    chk({tag, ".init"},  int'(init16), int'(m_init));
    chk({tag, ".init4"}, int'(init4),  int'(m_init));
    chk({tag, ".je"},    int'(je16),  int'(m_je));
    chk({tag, ".je4"},   int'(je4),   int'(m_je));
    chk({tag, ".ov16"},  int'(ov16),  int'(m_ov16));
    chk({tag, ".ov4"},   int'(ov4),   int'(m_ov4));
    chk({tag, ".sc16"},  int'(sc16),  m_sc16);
    chk({tag, ".sc4"},   int'(sc4),   m_sc4);
    chk({tag, ".sv"},    int'(sv16),  int'(m_sv));
    chk({tag, ".sv4"},   int'(sv4),   int'(m_sv));
  endtask

  task automatic model_reset();
    m_init = 0; m_je = 0; m_ov16 = 0; m_ov4 = 0; m_sv = 0;
    m_base = 0; m_t16 = 0; m_t4 = 0; m_sc16 = 0; m_sc4 = 0;
  endtask

  task automatic model_clear();
    m_t16 = 0; m_t4 = 0; m_je = 0; m_ov16 = 0; m_ov4 = 0;
  endtask

  // A stable value s was accepted.
  task automatic model_apply(input int s);
    int d;
    if (!m_init) begin
      m_init = 1;
      m_base = s;
    end else if (s != m_base) begin
      d = (s - m_base + 8) % 8;
      m_t16 += d;
      if (m_t16 >= 65536) begin m_t16 -= 65536; m_ov16 = 1; end
      m_t4 += d;
      if (m_t4 >= 16) begin m_t4 -= 16; m_ov4 = 1; end
      if (d > 3) m_je = 1;
      m_base = s;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold a value long enough to be accepted (n >= 5).
  task automatic hold(input logic [2:0] v, input int n);
    ripple = v;
    step(n);
    model_apply(int'(v));
  endtask

  task automatic adv(input int d, input int n);
    logic [2:0] v;
    v = 3'((m_base + d) % 8);
    hold(v, n);
  endtask

  // One-cycle control pulse; the snapshot sees the pre-clear total.
  task automatic op(input bit rq, input bit ak, input bit cl);
    sreq = rq; sack = ak; clr = cl;
    step(1);
    sreq = 0; sack = 0; clr = 0;
    if (!m_sv) begin
      if (rq) begin m_sc16 = m_t16; m_sc4 = m_t4; m_sv = 1; end
    end else if (ak) begin
      if (rq) begin m_sc16 = m_t16; m_sc4 = m_t4; end
      else m_sv = 0;
    end
    if (cl) model_clear();
  endtask

  initial begin
    reset_n = 0; ripple = 0; clr = 0; sreq = 0; sack = 0;
    model_reset();
    step(2);
    chk_all("reset");

    // baseline from the first stable value, no accumulation
    reset_n = 1; ripple = 3'd5;
    step(5);
    model_apply(5);
    chk_all("init");
    step(3);

    // exact latency of an update: visible on the 5th edge after the drive
    ripple = 3'd6;
    step(4);
    chk_all("lat_pre");
    step(1);
    model_apply(6);
    chk_all("lat");
    step(3);

    // 6,7,0,1 including the 7->0 wrap
    hold(3'd7, 8); chk_all("seq7");
    hold(3'd0, 8); chk_all("wrap");
    hold(3'd1, 8); chk_all("seq1");

    // one-cycle skew value is never accepted
    hold(3'd3, 8); chk_all("pre_glitch");
    ripple = 3'd2; step(1);
    hold(3'd4, 8); chk_all("glitch");

    // walk to baseline 1, then jump by 5
    for (int i = 0; i < 5; i++) adv(1, 7);
    chk_all("walk");
    hold(3'd6, 8); chk_all("jump");
    op(0, 0, 1); chk_all("clear");
    hold(3'd7, 8); chk_all("after_clear");

    // clear coinciding with acceptance of a jump: delta and flag discarded
    ripple = 3'd4;
    step(4);
    clr = 1; step(1); clr = 0;
    model_clear(); m_base = 4;
    chk_all("clr_accept");
    hold(3'd5, 8); chk_all("clr_accept_base");

    // 16 counts: 4-bit instance wraps to 0 and flags overflow
    op(0, 0, 1);
    for (int i = 0; i < 8; i++) adv(2, 7);
    chk_all("overflow");

    // snapshot handshake
    op(0, 0, 1);
    for (int i = 0; i < 3; i++) adv(3, 7);
    chk_all("snap_pre");
    op(1, 0, 0); chk_all("snap_take");
    adv(2, 7);   chk_all("snap_frozen");
    op(1, 0, 0); chk_all("snap_req_ignored");
    adv(1, 7);   chk_all("snap_t12");
    op(1, 1, 0); chk_all("snap_reload");
    op(0, 1, 0); chk_all("snap_ack");
    op(0, 1, 0); chk_all("ack_idle");
    op(1, 0, 1); chk_all("snap_clear");
    op(0, 1, 0); chk_all("snap_clear_ack");

    // randomized mix
    for (int i = 0; i < 80; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 4) begin
        adv(int'($urandom_range(0, 7)), int'($urandom_range(5, 10)));
      end else if (r == 5) begin
        ripple = 3'($urandom_range(0, 7));
        step(1);
        adv(int'($urandom_range(0, 7)), int'($urandom_range(5, 10)));
      end else if (r == 6) begin
        op(0, 0, 1);
      end else begin
        op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end
      chk_all("rand");
    end

    // asynchronous reset mid-operation, then a fresh baseline
    @(negedge clk);
    #2 reset_n = 0;
    #1 model_reset();
    chk_all("async_reset");
    @(negedge clk);
    reset_n = 1;
    hold(ripple, 6); chk_all("rebase");
    adv(2, 8);       chk_all("rebase_adv");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ripple_count_capture.md
Name: ripple_count_capture

Overview:
- Consumes the 3-bit output of the team's enable-gated ripple counter, which changes asynchronously and ripples bit by bit, and brings it into the system clock domain.
- Filters the ripple transients, then extends the wrapping 3-bit count into a wide running total.
- Provides a req/ack snapshot port so software or control logic can read a coherent total.

Parameters:
- IN_W, 3: width of ripple counter input.
- OUT_W, 16: width of accumulated total.
- STABLE_CYC, 2: consecutive equal synchronized samples required before a value is accepted (>=1).
- MAX_DELTA, 3: largest legal per-update advance; a larger delta sets jump_err.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ripple_q  in  IN_W  raw ripple counter output, asynchronous to clk.
- clear  in  1  synchronous: zero total and sticky flags.
- snap_req  in  1  single-cycle snapshot request.
- snap_ack  in  1  consumer has taken snap_count.
- total_count  out  OUT_W  running accumulated count.
- init_done  out  1  baseline established.
- snap_count  out  OUT_W  latched snapshot.
- snap_valid  out  1  snapshot held, awaiting ack.
- jump_err  out  1  sticky: delta exceeded MAX_DELTA.
- overflow  out  1  sticky: total_count wrapped past 2^OUT_W-1.

Behaviour:
- Reset (async, active-low): all outputs 0, synchronizer flops 0, stability counter 0, FSM to INIT, snapshot FSM to IDLE.
- Synchronization: 2-flop synchronizer on every ripple_q bit. Bit skew is tolerated only via the stability filter.
- Stability filter:
  - Counter increments while sync output equals its previous value, and resets to 0 on any change.
  - A value is "stable" when the counter reaches STABLE_CYC.
  - Acceptance happens exactly once per distinct stable value.
- Latency: ripple_q settled with setup met before edge N, so total_count shows the update after edge N+STABLE_CYC+2. This is 4 edges at default.
- Main FSM:
  - INIT: the first stable value is stored as baseline. No accumulation. Go to TRACK and set init_done=1.
  - TRACK: on accepting a stable value s different from baseline:
    - delta = (s - baseline) mod 2^IN_W, unsigned.
    - total_count += delta, modulo 2^OUT_W. A carry-out sets overflow.
    - delta > MAX_DELTA sets jump_err, and the delta is still added.
    - baseline <= s.
  - A stable value equal to baseline changes nothing.
  - Counter wrap 7->0 gives delta 1. 6->1 gives delta 3.
- clear (TRACK or INIT):
  - total_count <= 0; jump_err, overflow <= 0.
  - FSM state and init_done are unchanged.
  - If accepted the same cycle: baseline updates to s, delta is discarded, and flags are not set by that delta.
- Snapshot FSM:
  - IDLE: snap_req loads snap_count <= total_count (pre-update value of that cycle), sets snap_valid=1, go to HOLD.
  - HOLD: snap_count is frozen.
    - snap_ack alone: snap_valid=0, go to IDLE.
    - snap_ack and snap_req in the same cycle: reload snap_count, snap_valid stays 1.
    - snap_req without ack: ignored.
  - snap_ack in IDLE is ignored.
- clear does not affect snap_count or snap_valid.
- Snapshot sees the pre-clear value when clear and snap_req coincide.
- Reset mid-operation: immediate return to reset values. Baseline is re-established from the next stable value.

Test Plan:
- Reset, then hold ripple_q=5 -> init_done=1 after 4 edges, total_count=0.
- From baseline 5, step ripple_q 6,7,0,1, each held 8 cycles -> total_count=4, jump_err=0; 7->0 wrap counted as 1.
- Transient: ripple_q 3 -> 2 for 1 cycle -> 4 (3->4 ripple glitch), STABLE_CYC=2 -> 2 is never accepted, total +1, jump_err=0.
- Jump: baseline 1, ripple_q=6 -> total +5, jump_err=1. Then clear -> total_count=0, jump_err=0, baseline=6.
- Overflow: OUT_W=4, advance 16 counts -> total_count wraps to 0, overflow=1.
- Snapshot:
  - total=9, snap_req -> snap_count=9, snap_valid=1.
  - Further counts leave snap_count=9.
  - Second snap_req is ignored.
  - snap_ack+snap_req with total=12 -> snap_count=12, snap_valid=1.
  - snap_ack -> snap_valid=0.
